// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM capture block.
package pwm_pkg;

    localparam int unsigned PWM_W           = 9;
    localparam int unsigned PWM_PERIOD      = 512;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;
    localparam int unsigned CNT_W           = 11;
    localparam int unsigned HI_W            = 10;

    typedef enum logic [1:0] {
        StArm,
        StWaitRise,
        StHigh,
        StLow
    } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM line plus rise/fall detection
// against a third delay flop.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= pwm_in;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign pwm_s = sync_q;
    assign rise  = sync_q & ~dly_q;
    assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of a PWM line, with stuck-line timeouts.
// Optional period check against the nominal frame: define PWM_CAPTURE_PERIOD_CHECK_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [PWM_W-1:0] value,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck_low,
    output logic             stuck_high,
    output logic             period_err
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SyncFill   = CNT_W'(2);
    localparam logic [PWM_W-1:0] ValueMax   = '1;

    logic pwm_s, rise, fall;

    pwm_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .pwm_s  (pwm_s),
        .rise   (rise),
        .fall   (fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [HI_W-1:0]  hi_q, hi_d, hi_inc;
    logic [PWM_W-1:0] value_q, value_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stuck_low_q, stuck_low_d;
    logic             stuck_high_q, stuck_high_d;
    logic             perr_q, perr_d;
    logic             timeout, primed, per_bad;
    logic             pub_edge, pub_low, pub_high;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign hi_inc  = (hi_q == '1) ? hi_q : hi_q + HI_W'(1);
    // >= so a fall landing on the timeout cycle still times out one cycle later in LOW
    assign timeout = (cnt_inc >= TimeoutCnt);
    // Synchronizer holds reset zeros for two cycles; don't trust pwm_s=0 before then
    assign primed  = (cnt_q >= SyncFill);

`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
    localparam logic [CNT_W-1:0] PeriodNom = CNT_W'(PWM_PERIOD);
    assign per_bad = (cnt_q != PeriodNom);
`else
    assign per_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StArm;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArm:      if (!timeout && !pwm_s && primed) state_d = StWaitRise;
            StWaitRise: if (rise) state_d = StHigh;
            StHigh: begin
                if (fall)         state_d = StLow;
                else if (timeout) state_d = StArm;
            end
            StLow: begin
                if (rise)         state_d = StHigh;
                else if (timeout) state_d = StWaitRise;
            end
            default: state_d = StArm;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_inc;
        hi_d         = hi_q;
        value_d      = value_q;
        period_d     = period_q;
        stuck_low_d  = stuck_low_q;
        stuck_high_d = stuck_high_q;
        perr_d       = perr_q;
        valid_d      = 1'b0;
        pub_edge     = 1'b0;
        pub_low      = 1'b0;
        pub_high     = 1'b0;
        unique case (state_q)
            StArm: pub_high = timeout;
            StWaitRise: begin
                if (rise) begin
                    hi_d  = HI_W'(1);
                    cnt_d = CNT_W'(1);
                end else begin
                    pub_low = timeout;
                end
            end
            StHigh: begin
                if (!fall) begin
                    if (timeout) pub_high = 1'b1;
                    else         hi_d     = hi_inc;
                end
            end
            StLow: begin
                if (rise) pub_edge = 1'b1;
                else      pub_low  = timeout;
            end
            default: ;
        endcase

        if (pub_edge) begin
            value_d      = (hi_q > HI_W'(ValueMax)) ? ValueMax : hi_q[PWM_W-1:0];
            period_d     = cnt_q;
            stuck_low_d  = 1'b0;
            stuck_high_d = 1'b0;
            perr_d       = per_bad;
            valid_d      = 1'b1;
            hi_d         = HI_W'(1);
            cnt_d        = CNT_W'(1);
        end else if (pub_low || pub_high) begin
            value_d      = pub_high ? ValueMax : '0;
            stuck_low_d  = pub_low;
            stuck_high_d = pub_high;
            perr_d       = 1'b0;
            valid_d      = 1'b1;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            hi_q         <= '0;
            value_q      <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            stuck_low_q  <= 1'b0;
            stuck_high_q <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            value_q      <= value_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_low_q  <= stuck_low_d;
            stuck_high_q <= stuck_high_d;
            perr_q       <= perr_d;
        end
    end

    assign value      = value_q;
    assign period     = period_q;
    assign valid      = valid_q;
    assign stuck_low  = stuck_low_q;
    assign stuck_high = stuck_high_q;
    assign period_err = perr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a line-level model pushes expected updates as the
// PWM line is driven; a negedge monitor pops and compares them on each valid.
module tb_pwm_capture;

    localparam int unsigned TO = 1024;
`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
    localparam bit PerrEn = 1'b1;
`else
    localparam bit PerrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [8:0]  value;
    logic [10:0] period;
    logic        valid, stuck_low, stuck_high, period_err;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .value      (value),
        .period     (period),
        .valid      (valid),
        .stuck_low  (stuck_low),
        .stuck_high (stuck_high),
        .period_err (period_err)
    );

    typedef struct {
        int unsigned cyc;
        int unsigned value;
        int unsigned period;
        bit          sl;
        bit          sh;
        bit          perr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Line model state
    bit          line = 1'b0;
    bit          seen_low = 1'b0;
    bit          meas_ok = 1'b0;
    int unsigned rise_c = 0, fall_c = 0, c0 = 0;
    int unsigned last_value = 0, last_period = 0;
    bit          last_sl = 1'b0, last_sh = 1'b0, last_perr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input int unsigned exp);
        n_checks++;
        if (obs !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int unsigned c, input int unsigned v,
                                input int unsigned p, input bit sl, input bit sh,
                                input bit pe);
        exp_t e;
        e.cyc = c; e.value = v; e.period = p; e.sl = sl; e.sh = sh; e.perr = pe;
        return e;
    endfunction

    // Drive one cycle of the line; a rise after a full measured frame predicts an update.
    task automatic drive(input bit v);
        int unsigned hi, per;
        @(negedge clk);
        if (v && !line) begin
            if (meas_ok) begin
                hi  = fall_c - rise_c;
                per = cyc - rise_c;
                sb.push_back(mk(cyc + 3, (hi > 511) ? 511 : hi, (per > 2047) ? 2047 : per,
                                1'b0, 1'b0, PerrEn && (per != 512)));
            end
            rise_c  = cyc;
            meas_ok = seen_low;
        end
        if (!v && line) fall_c = cyc;
        if (!v) seen_low = 1'b1;
        line   = v;
        pwm_in = v;
    endtask

    task automatic gen_frames(input int unsigned duty, input int unsigned n,
                              input int unsigned frame);
        for (int f = 0; f < int'(n); f++)
            for (int ph = 0; ph < int'(frame); ph++)
                drive(ph < int'(duty));
    endtask

    task automatic do_reset();
        check("sb_drained", sb.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", value, 0);
        check("rst_period", period, 0);
        check("rst_valid", valid, 0);
        check("rst_flags", {stuck_low, stuck_high, period_err}, 0);
        sb.delete();
        meas_ok = 1'b0; seen_low = 1'b0;
        last_value = 0; last_period = 0; last_sl = 1'b0; last_sh = 1'b0; last_perr = 1'b0;
        rst = 1'b0;
        c0  = cyc;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    check("valid_unexpected", valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("latency", cyc, mon_e.cyc);
                    check("value", value, mon_e.value);
                    check("period", period, mon_e.period);
                    check("stuck_low", stuck_low, mon_e.sl);
                    check("stuck_high", stuck_high, mon_e.sh);
                    check("period_err", period_err, mon_e.perr);
                    last_value = mon_e.value; last_period = mon_e.period;
                    last_sl = mon_e.sl; last_sh = mon_e.sh; last_perr = mon_e.perr;
                end
            end else begin
                check("hold", {value, period, stuck_low, stuck_high, period_err},
                      {last_value[8:0], last_period[10:0], last_sl, last_sh, last_perr});
                if (sb.size() != 0 && cyc > sb[0].cyc) begin
                    check("valid_missing", valid, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);

        // Free-running duty 100
        do_reset();
        repeat (8) drive(1'b0);
        gen_frames(100, 6, 512);
        repeat (8) drive(1'b0);

        // Duty 0: stuck_low every TO cycles from reset release
        do_reset();
        for (int k = 1; k <= 3; k++)
            sb.push_back(mk(c0 + TO * k, 0, 0, 1'b1, 1'b0, 1'b0));
        repeat (3 * TO + 4) drive(1'b0);

        // Duty 511, then line forced high
        do_reset();
        repeat (8) drive(1'b0);
        gen_frames(511, 4, 512);
        drive(1'b1);
        sb.push_back(mk(rise_c + 2 + TO, 511, 512, 1'b0, 1'b1, 1'b0));
        repeat (1099) drive(1'b1);
        meas_ok  = 1'b0;
        seen_low = 1'b0;
        repeat (8) drive(1'b0);

        // Duty 100 -> 300 changed mid-frame
        do_reset();
        repeat (8) drive(1'b0);
        gen_frames(100, 3, 512);
        for (int ph = 0; ph < 512; ph++) drive(ph < ((ph < 50) ? 100 : 300));
        gen_frames(300, 3, 512);
        repeat (4) drive(1'b0);

        // Reset while the line is high mid-frame
        gen_frames(100, 2, 512);
        repeat (50) drive(1'b1);
        do_reset();
        repeat (20) drive(1'b1);
        gen_frames(100, 4, 512);
        repeat (4) drive(1'b0);

        // Off-nominal 400-cycle frame, 150 high
        do_reset();
        repeat (8) drive(1'b0);
        gen_frames(150, 4, 400);
        repeat (8) drive(1'b0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
